// File: rtl/piso_pkg.sv
// Shared types and helpers for the parallel-in serial-out transmitter.
// No logic of its own; no latency.
// No flow control of its own.
package piso_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Bit-counter width; never below one bit so WIDTH=2 still gets a counter.
    function automatic int cnt_width(input int w);
        return (w > 2) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_datapath.sv
// Shift register and bit counter for the PISO transmitter; head bit is always bit 0.
// Load or shift takes effect on the next edge; head/first/last are purely registered.
// No backpressure of its own; the FSM gates load_en/shift_en with the pacing input.
module piso_shift_datapath
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic [WIDTH-1:0] data_parallel,
    output logic             head,
    output logic             first,
    output logic             last
);

    localparam int CW = cnt_width(WIDTH);

    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] load_word;
    logic [CW-1:0]    cnt;

    // MSB-first words are stored reversed so the shifter always drains from bit 0.
    always_comb begin
        load_word = data_parallel;
        if (!LSB_FIRST) begin
            for (int i = 0; i < WIDTH; i++) begin
                load_word[i] = data_parallel[WIDTH-1-i];
            end
        end
    end

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load_en) begin
            shreg <= load_word;
            cnt   <= '0;
        end else if (shift_en) begin
            shreg <= {1'b0, shreg[WIDTH-1:1]};
            cnt   <= cnt + CW'(1);
        end
    end

    assign head  = shreg[0];
    assign first = (cnt == '0);
    assign last  = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/piso_transmitter.sv
// Parallel-in serial-out transmitter: word accepted on ready&load, sent one bit per enabled cycle.
// First bit appears the cycle after accept; done pulses after the last bit; ready returns one cycle later.
// enable=0 in SHIFT stalls the frame one cycle per low cycle; load is ignored unless ready=1.
module piso_transmitter
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic             clockpulse,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] data_parallel,
    input  logic             enable,
    output logic             ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             done
);

    state_t state;
    state_t state_nxt;
    logic   load_en;
    logic   shift_en;
    logic   head;
    logic   first;
    logic   last;

    piso_shift_datapath #(
        .WIDTH     (WIDTH),
        .LSB_FIRST (LSB_FIRST)
    ) u_datapath (
        .clockpulse    (clockpulse),
        .clear         (clear),
        .load_en       (load_en),
        .shift_en      (shift_en),
        .data_parallel (data_parallel),
        .head          (head),
        .first         (first),
        .last          (last)
    );

    always_ff @(posedge clockpulse) begin
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        load_en      = 1'b0;
        shift_en     = 1'b0;
        ready        = 1'b0;
        serial_out   = 1'b0;
        serial_valid = 1'b0;
        frame_start  = 1'b0;
        done         = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (load) begin
                    load_en   = 1'b1;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                serial_out   = head;
                serial_valid = enable;
                frame_start  = first & enable;
                // The last bit leaves via the state change, so the counter never wraps.
                if (enable) begin
                    if (last) begin
                        state_nxt = DONE;
                    end else begin
                        shift_en = 1'b1;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule
